mbist_march_ctrl: RTL and testbench

March C- initiator that drives the memory-under-test port (`write_read`, `address`, `wdata`) of `fault_mem` and checks its `rdata`. Sits between the chip-level BIST start/status logic and one memory instance, with one memory operation per clock. Reports pass/fail, the first failing address, and a saturating mismatch count.

---
 rtl/mbist_pkg.sv | 34 +++
 rtl/mbist_resp_checker.sv | 57 +++++
 rtl/mbist_march_ctrl.sv | 140 ++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// March C- controller types: FSM states and the element ROM walked by the sequencer.
// Each element lists direction, op count, and read/write polarity (0 = background, 1 = inverse).
package mbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // has_rd marks whether phase 0 is a read; a second phase, when present, is always the write.
  typedef struct packed {
    logic       down;
    logic [1:0] nops;
    logic       has_rd;
    logic       rd_pol;
    logic       wr_pol;
  } elem_t;

  localparam int         NUM_ELEMS = 6;
  localparam logic [2:0] LAST_ELEM = 3'd5;

  localparam elem_t MARCH_ROM [NUM_ELEMS] = '{
    '{1'b0, 2'd1, 1'b0, 1'b0, 1'b0},  // up   w(D)
    '{1'b0, 2'd2, 1'b1, 1'b0, 1'b1},  // up   r(D)  w(~D)
    '{1'b0, 2'd2, 1'b1, 1'b1, 1'b0},  // up   r(~D) w(D)
    '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1},  // down r(D)  w(~D)
    '{1'b1, 2'd2, 1'b1, 1'b1, 1'b0},  // down r(~D) w(D)
    '{1'b0, 2'd1, 1'b1, 1'b0, 1'b0}   // up   r(D)
  };

endpackage

// File: rtl/mbist_resp_checker.sv
// Read-response checker: delays {valid, expected, address} two cycles to meet rdata, then compares.
// Sticky fail, first-failing address capture and a saturating mismatch counter; clr wipes all.
module mbist_resp_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  op_vld,
  input  logic [DATA_WIDTH-1:0] op_exp,
  input  logic [ADDR_WIDTH-1:0] op_addr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [CNT_WIDTH-1:0]  fail_count
);

  logic                  vld1, vld2;
  logic [DATA_WIDTH-1:0] exp1, exp2;
  logic [ADDR_WIDTH-1:0] addr1, addr2;
  logic                  mismatch;

  assign mismatch = vld2 && (rdata != exp2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld1       <= 1'b0;
      vld2       <= 1'b0;
      exp1       <= '0;
      exp2       <= '0;
      addr1      <= '0;
      addr2      <= '0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_count <= '0;
    end else begin
      vld1  <= op_vld && !clr;
      vld2  <= vld1 && !clr;
      exp1  <= op_exp;
      exp2  <= exp1;
      addr1 <= op_addr;
      addr2 <= addr1;
      if (clr) begin
        fail       <= 1'b0;
        fail_addr  <= '0;
        fail_count <= '0;
      end else if (mismatch) begin
        fail <= 1'b1;
        if (!fail) fail_addr <= addr2;
        if (fail_count != '1) fail_count <= fail_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- initiator: one memory op per clock, 10*CAPACITY ops, done 3 cycles after the last op.
// The sequencer pointer runs one op ahead so wdata can lead its write by a cycle.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    CAPACITY   = 16,
  parameter logic [DATA_WIDTH-1:0] BG_PATTERN = '0,
  parameter int                    CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                state;
  logic [2:0]            p_elem, n_elem;
  logic                  p_ph, n_ph;
  logic [ADDR_WIDTH-1:0] p_addr, n_addr, end_addr;
  elem_t                 ce;
  logic                  p_is_rd, p_pol, n_pol, p_final;
  logic                  last_op, drain_cnt, rd_vld, accept, issue;
  logic [DATA_WIDTH-1:0] rd_exp;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic pol);
    return pol ? ~BG_PATTERN : BG_PATTERN;
  endfunction

  // Current op from the pointer, plus the pointer's successor for the wdata look-ahead.
  always_comb begin
    ce       = MARCH_ROM[p_elem];
    p_is_rd  = ce.has_rd && !p_ph;
    p_pol    = p_is_rd ? ce.rd_pol : ce.wr_pol;
    end_addr = ce.down ? '0 : LAST_ADDR;
    p_final  = (p_elem == LAST_ELEM) && (p_addr == end_addr);
    n_elem   = p_elem;
    n_ph     = 1'b0;
    n_addr   = p_addr;
    if (!p_ph && ce.nops == 2'd2) begin
      n_ph = 1'b1;
    end else if (p_addr == end_addr) begin
      if (p_elem != LAST_ELEM) n_elem = p_elem + 3'd1;
      n_addr = MARCH_ROM[n_elem].down ? LAST_ADDR : '0;
    end else begin
      n_addr = ce.down ? p_addr - ADDR_ONE : p_addr + ADDR_ONE;
    end
    n_pol = (MARCH_ROM[n_elem].has_rd && !n_ph) ? MARCH_ROM[n_elem].rd_pol
                                                : MARCH_ROM[n_elem].wr_pol;
  end

  assign accept = start && (state == ST_IDLE || state == ST_DONE);
  assign issue  = (state == ST_PRE) || (state == ST_RUN && !last_op);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      write_read <= 1'b0;
      address    <= '0;
      wdata      <= BG_PATTERN;
      p_elem     <= '0;
      p_ph       <= 1'b0;
      p_addr     <= '0;
      last_op    <= 1'b0;
      drain_cnt  <= 1'b0;
      rd_vld     <= 1'b0;
      rd_exp     <= BG_PATTERN;
    end else begin
      if (accept) begin
        state   <= ST_PRE;
        busy    <= 1'b1;
        done    <= 1'b0;
        address <= '0;
        wdata   <= BG_PATTERN;
        p_elem  <= '0;
        p_ph    <= 1'b0;
        p_addr  <= '0;
        last_op <= 1'b0;
      end
      if (issue) begin
        state      <= ST_RUN;
        write_read <= !p_is_rd;
        address    <= p_addr;
        rd_vld     <= p_is_rd;
        rd_exp     <= pat(p_pol);
        wdata      <= pat(n_pol);
        p_elem     <= n_elem;
        p_ph       <= n_ph;
        p_addr     <= n_addr;
        last_op    <= p_final;
      end
      if (state == ST_RUN && last_op) begin
        state      <= ST_DRAIN;
        write_read <= 1'b0;
        rd_vld     <= 1'b0;
        drain_cnt  <= 1'b0;
      end
      if (state == ST_DRAIN) begin
        drain_cnt <= 1'b1;
        if (drain_cnt) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  mbist_resp_checker #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept),
    .op_vld    (rd_vld),
    .op_exp    (rd_exp),
    .op_addr   (address),
    .rdata     (rdata),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_count(fail_count)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two DUTs (8-bit and 2-bit fail counters) each on a fault_mem model,
// checked against a march-level op list and fault outcome computed from the element table.
module tb_mbist_march_ctrl;

  localparam int          CAP         = 16;
  localparam logic [7:0]  BG          = 8'h00;
  localparam int          LAST_OP_CYC = 1 + 10 * CAP;
  localparam int          DONE_CYC    = 4 + 10 * CAP;
  localparam int          RUN_CYCLES  = DONE_CYC + 6;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic       fault_en;
  logic [3:0] fault_a;
  logic [7:0] fault_v;

  logic       busy_a, done_a, fail_a, wr_a;
  logic [3:0] fail_addr_a, addr_a;
  logic [7:0] fail_count_a, wdata_a, rdata_a, wq_a, r1_a;
  logic [7:0] mem_a [CAP];

  logic       busy_b, done_b, fail_b, wr_b;
  logic [3:0] fail_addr_b, addr_b;
  logic [1:0] fail_count_b;
  logic [7:0] wdata_b, rdata_b, wq_b, r1_b;
  logic [7:0] mem_b [CAP];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         wr;
    int         addr;
    logic [7:0] data;
  } op_t;
  op_t ref_ops[$];

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(CAP), .BG_PATTERN(BG), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a), .done(done_a), .fail(fail_a),
    .fail_addr(fail_addr_a), .fail_count(fail_count_a), .write_read(wr_a), .address(addr_a),
    .wdata(wdata_a), .rdata(rdata_a));

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(CAP), .BG_PATTERN(BG), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_b), .done(done_b), .fail(fail_b),
    .fail_addr(fail_addr_b), .fail_count(fail_count_b), .write_read(wr_b), .address(addr_b),
    .wdata(wdata_b), .rdata(rdata_b));

  // fault_mem: wdata latched one edge before the write commits; read data returns two cycles later.
  always @(posedge clk) begin
    wq_a <= wdata_a;
    if (wr_a) mem_a[addr_a] <= wq_a;
    r1_a    <= (fault_en && addr_a == fault_a) ? fault_v : mem_a[addr_a];
    rdata_a <= r1_a;
  end

  always @(posedge clk) begin
    wq_b <= wdata_b;
    if (wr_b) mem_b[addr_b] <= wq_b;
    r1_b    <= (fault_en && addr_b == fault_a) ? fault_v : mem_b[addr_b];
    rdata_b <= r1_b;
  end

  function automatic void push_elem(bit down, bit rd, bit rpol, bit wr, bit wpol);
    for (int i = 0; i < CAP; i++) begin
      int a;
      a = down ? CAP - 1 - i : i;
      if (rd) ref_ops.push_back('{1'b0, a, rpol ? ~BG : BG});
      if (wr) ref_ops.push_back('{1'b1, a, wpol ? ~BG : BG});
    end
  endfunction

  // A stuck word returns fv on every read at fa; each read expecting something else is a mismatch.
  function automatic void ref_result(input bit en, input int fa, input logic [7:0] fv,
                                     output int cnt, output int faddr);
    cnt   = 0;
    faddr = 0;
    foreach (ref_ops[i]) begin
      if (en && !ref_ops[i].wr && ref_ops[i].addr == fa && ref_ops[i].data != fv) begin
        if (cnt == 0) faddr = fa;
        cnt++;
      end
    end
  endfunction

  // Cycle c begins at edge k+c-1 where k is the start edge; outputs sampled at the negedge of cycle c.
  task automatic run_march(input string name, input bit en, input int fa, input logic [7:0] fv,
                           input bit noise);
    int         exp_cnt, exp_addr, exp_sat;
    int         op_err, bw_err, done_cyc;
    logic [7:0] prev_wd;
    op_t        o;
    op_err   = 0;
    bw_err   = 0;
    done_cyc = -1;
    prev_wd  = 'x;
    fault_en = en;
    fault_a  = fa[3:0];
    fault_v  = fv;
    ref_result(en, fa, fv, exp_cnt, exp_addr);
    exp_sat = (exp_cnt > 3) ? 3 : exp_cnt;

    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= RUN_CYCLES; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= LAST_OP_CYC) begin
        o = ref_ops[c - 2];
        if (wr_a !== o.wr || addr_a !== o.addr[3:0]) op_err++;
        if (o.wr && prev_wd !== o.data) op_err++;
      end else if (wr_a !== 1'b0 || wr_b !== 1'b0) begin
        op_err++;
      end
      if (busy_a !== (c < DONE_CYC)) bw_err++;
      if (done_a !== (c >= DONE_CYC)) bw_err++;
      if (done_a === 1'b1 && done_cyc < 0) done_cyc = c;
      if (c == 1) begin
        checks++;
        if (fail_a !== 1'b0 || fail_count_a !== 8'd0 || fail_addr_a !== 4'd0 || done_a !== 1'b0) begin
          errors++;
          $display("FAIL %s start_clear: fail=%b cnt=%0d addr=%0d done=%b, required all zero",
                   name, fail_a, fail_count_a, fail_addr_a, done_a);
        end
      end
      prev_wd = wdata_a;
      if (noise) start = (c <= 150) && ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;

    checks++;
    if (op_err !== 0) begin
      errors++;
      $display("FAIL %s op_seq: %0d op mismatches, required 0", name, op_err);
    end
    checks++;
    if (bw_err !== 0) begin
      errors++;
      $display("FAIL %s busy_done_window: %0d bad cycles, required 0", name, bw_err);
    end
    checks++;
    if (done_cyc !== DONE_CYC) begin
      errors++;
      $display("FAIL %s done_cycle: got cycle %0d, required %0d", name, done_cyc, DONE_CYC);
    end
    checks++;
    if (fail_a !== (exp_cnt > 0)) begin
      errors++;
      $display("FAIL %s fail: got %b, required %b", name, fail_a, exp_cnt > 0);
    end
    checks++;
    if (fail_addr_a !== exp_addr[3:0]) begin
      errors++;
      $display("FAIL %s fail_addr: got %0d, required %0d", name, fail_addr_a, exp_addr);
    end
    checks++;
    if (fail_count_a !== exp_cnt[7:0]) begin
      errors++;
      $display("FAIL %s fail_count: got %0d, required %0d", name, fail_count_a, exp_cnt);
    end
    checks++;
    if (fail_count_b !== exp_sat[1:0] || fail_addr_b !== exp_addr[3:0]) begin
      errors++;
      $display("FAIL %s sat_counter: got cnt=%0d addr=%0d, required cnt=%0d addr=%0d",
               name, fail_count_b, fail_addr_b, exp_sat, exp_addr);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL %s busy: got %b, required 0", name, busy_a); end
    checks++;
    if (done_a !== 1'b0) begin errors++; $display("FAIL %s done: got %b, required 0", name, done_a); end
    checks++;
    if (fail_a !== 1'b0) begin errors++; $display("FAIL %s fail: got %b, required 0", name, fail_a); end
    checks++;
    if (wr_a !== 1'b0) begin errors++; $display("FAIL %s write_read: got %b, required 0", name, wr_a); end
    checks++;
    if (fail_addr_a !== 4'd0) begin errors++; $display("FAIL %s fail_addr: got %0d, required 0", name, fail_addr_a); end
    checks++;
    if (fail_count_a !== 8'd0) begin errors++; $display("FAIL %s fail_count: got %0d, required 0", name, fail_count_a); end
    checks++;
    if (addr_a !== 4'd0) begin errors++; $display("FAIL %s address: got %0d, required 0", name, addr_a); end
    checks++;
    if (wdata_a !== BG) begin errors++; $display("FAIL %s wdata: got %h, required %h", name, wdata_a, BG); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fault_free();
    run_march("fault_free", 1'b0, 0, 8'h00, 1'b0);
  endtask

  task automatic test_fixed_faults();
    run_march("fault5_a5", 1'b1, 5, 8'hA5, 1'b0);
    run_march("fault5_00", 1'b1, 5, 8'h00, 1'b0);
    run_march("fault15_ff", 1'b1, 15, 8'hFF, 1'b0);
  endtask

  task automatic test_reset_mid();
    fault_en = 1'b1;
    fault_a  = 4'd5;
    fault_v  = 8'hA5;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (95) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("reset_mid");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_march("after_reset", 1'b1, 5, 8'hA5, 1'b0);
  endtask

  task automatic test_saturation();
    run_march("saturate", 1'b1, 5, 8'hA5, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_march("start_busy", 1'b1, int'($urandom_range(0, CAP - 1)), 8'(($urandom_range(0, 255))), 1'b1);
  endtask

  task automatic test_back_to_back();
    run_march("b2b_fault", 1'b1, 9, 8'h3C, 1'b0);
    run_march("b2b_clean", 1'b0, 0, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++)
      run_march("random", 1'b1, int'($urandom_range(0, CAP - 1)), 8'(($urandom_range(0, 255))),
                1'($urandom_range(0, 1)));
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    fault_en = 1'b0;
    fault_a  = 4'd0;
    fault_v  = 8'h00;
    push_elem(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_elem(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    push_elem(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push_elem(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    push_elem(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    push_elem(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_fault_free();
    test_fixed_faults();
    test_reset_mid();
    test_saturation();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before the test sequence ended");
    $fatal(1, "watchdog expired");
  end

endmodule
